// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_sequencer_pkg;

  // Controller states, binary encoded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width for a given operand width (operand width is 2 or more)
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Requester-side handshake and operand/result bus of the serial adder.
interface serial_add_sequencer_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, x, y, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, x, y, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/one_bit_full_adder.sv
// Combinational single-bit full adder cell, shared across all bit positions.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of one bit column
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first,
// producing a WIDTH-bit sum and carry-out after WIDTH RUN cycles.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_add_sequencer_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] ss;
  logic             cf;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             running;
  logic             last_bit;

  one_bit_full_adder u_fa (
    .a    (xs[0]),
    .b    (ys[0]),
    .cin  (cf),
    .s    (fa_sum),
    .cout (fa_cout)
  );

  assign accept   = bus.start && (state_q != ST_RUN);
  assign running  = (state_q == ST_RUN);
  assign last_bit = running && (cnt == LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept from IDLE/DONE, leave RUN after the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (cnt == LAST_BIT) state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, serial shifting and result latch on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs          <= '0;
      ys          <= '0;
      ss          <= '0;
      cf          <= 1'b0;
      cnt         <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      xs  <= bus.x;
      ys  <= bus.y;
      cf  <= bus.carry_in;
      cnt <= '0;
    end else if (running) begin
      xs <= xs >> 1;
      ys <= ys >> 1;
      ss <= {fa_sum, ss[WIDTH-1:1]};
      cf <= fa_cout;
      if (last_bit) begin
        sum_q       <= {fa_sum, ss[WIDTH-1:1]};
        carry_out_q <= fa_cout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for the serial adder at WIDTH=8 and WIDTH=16.
module tb_serial_add_sequencer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_add_sequencer_if #(.WIDTH(8))  bus8 ();
  serial_add_sequencer_if #(.WIDTH(16)) bus16 ();

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_add_sequencer #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full 8-bit operation; operands are scrambled after the accept edge
  task automatic apply_stimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic [7:0] exp_sum, input logic exp_co);
    logic [7:0] prev_sum;
    prev_sum       = bus8.sum;
    bus8.start     = 1'b1;
    bus8.x         = a;
    bus8.y         = b;
    bus8.carry_in  = cin;
    tick();
    bus8.start     = 1'b0;
    bus8.x         = 8'h00;
    bus8.y         = 8'h00;
    bus8.carry_in  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check_output({tag, " busy"}, 32'(bus8.busy), 32'd1);
      check_output({tag, " sum hold"}, 32'(bus8.sum), 32'(prev_sum));
      tick();
    end
    check_output({tag, " done"}, 32'(bus8.done), 32'd1);
    check_output({tag, " sum"}, 32'(bus8.sum), 32'(exp_sum));
    check_output({tag, " carry_out"}, 32'(bus8.carry_out), 32'(exp_co));
    tick();
    check_output({tag, " idle done"}, 32'(bus8.done), 32'd0);
    check_output({tag, " idle busy"}, 32'(bus8.busy), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus8.start = 1'b0;  bus8.x = '0;  bus8.y = '0;  bus8.carry_in = 1'b0;
    bus16.start = 1'b0; bus16.x = '0; bus16.y = '0; bus16.carry_in = 1'b0;
    #12;
    check_output("reset busy", 32'(bus8.busy), 32'd0);
    check_output("reset done", 32'(bus8.done), 32'd0);
    check_output("reset sum", 32'(bus8.sum), 32'd0);
    check_output("reset carry_out", 32'(bus8.carry_out), 32'd0);
    check_output("reset16 sum", 32'(bus16.sum), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] basic adds");
    apply_stimulus("5A+3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    apply_stimulus("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    apply_stimulus("FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    apply_stimulus("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    apply_stimulus("A5+5A+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    apply_stimulus("3C+0F+1", 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0);

    $display("[TB] start held through RUN, back-to-back");
    bus8.start = 1'b1; bus8.x = 8'h10; bus8.y = 8'h20; bus8.carry_in = 1'b0;
    tick();
    bus8.x = 8'h77; bus8.y = 8'h11;
    for (int i = 1; i <= 8; i++) begin
      check_output("b2b first busy", 32'(bus8.busy), 32'd1);
      tick();
    end
    check_output("b2b first done", 32'(bus8.done), 32'd1);
    check_output("b2b first sum", 32'(bus8.sum), 32'h30);
    tick();
    bus8.start = 1'b0; bus8.x = 8'h00; bus8.y = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      check_output("b2b second busy", 32'(bus8.busy), 32'd1);
      check_output("b2b second sum hold", 32'(bus8.sum), 32'h30);
      tick();
    end
    check_output("b2b second done", 32'(bus8.done), 32'd1);
    check_output("b2b second sum", 32'(bus8.sum), 32'h88);
    check_output("b2b second carry_out", 32'(bus8.carry_out), 32'd0);
    tick();

    $display("[TB] reset mid-RUN");
    bus8.start = 1'b1; bus8.x = 8'hAA; bus8.y = 8'h55; bus8.carry_in = 1'b0;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick();
    check_output("pre-reset busy", 32'(bus8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid reset busy", 32'(bus8.busy), 32'd0);
    check_output("mid reset done", 32'(bus8.done), 32'd0);
    check_output("mid reset sum", 32'(bus8.sum), 32'd0);
    check_output("mid reset carry_out", 32'(bus8.carry_out), 32'd0);
    tick();
    rst_n = 1'b1;
    apply_stimulus("01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    $display("[TB] WIDTH=16");
    bus16.start = 1'b1; bus16.x = 16'hFFFF; bus16.y = 16'h0001; bus16.carry_in = 1'b0;
    tick();
    bus16.start = 1'b0; bus16.x = 16'h0000; bus16.y = 16'h0000;
    for (int i = 1; i <= 16; i++) begin
      check_output("w16 busy", 32'(bus16.busy), 32'd1);
      check_output("w16 early done", 32'(bus16.done), 32'd0);
      tick();
    end
    check_output("w16 done", 32'(bus16.done), 32'd1);
    check_output("w16 sum", 32'(bus16.sum), 32'h0000);
    check_output("w16 carry_out", 32'(bus16.carry_out), 32'd1);
    tick();
    check_output("w16 idle", 32'(bus16.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
